// File: rtl/gf_inv_seq.sv
// Sequential GF(2^m) inverter: a^-1 = a^(2^m-2) via one squaring and one
// multiplication per cycle, over three built-in fields or a programmable one.
module gf_inv_seq #(
    parameter int M_MAX = 10,
    parameter int CNT_W = 5
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_in_ready,
    input  logic [M_MAX-1:0]               i_a,
    input  logic [1:0]                     i_code,
    input  logic [$clog2(M_MAX+1)-1:0]     i_m,
    input  logic [M_MAX-1:0]               i_poly,
    output logic                           o_valid,
    input  logic                           i_out_ready,
    output logic [M_MAX-1:0]               o_inv,
    output logic                           o_err
);
    localparam int MW = $clog2(M_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [M_MAX-1:0] low_mask(input logic [MW-1:0] m);
        logic [M_MAX-1:0] mk;
        for (int i = 0; i < M_MAX; i++) begin
            mk[i] = (i < int'(m)) ? 1'b1 : 1'b0;
        end
        return mk;
    endfunction

    // Carry-less product, then reduce from the top bit down using x^m = poly.
    function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] x,
                                                 input logic [M_MAX-1:0] y,
                                                 input logic [M_MAX-1:0] poly,
                                                 input logic [MW-1:0]    m);
        logic [2*M_MAX-2:0] prod;
        logic [2*M_MAX-2:0] pfull;
        prod  = '0;
        for (int i = 0; i < M_MAX; i++) begin
            if (y[i]) prod = prod ^ ({{(M_MAX-1){1'b0}}, x} << i);
            else      prod = prod;
        end
        pfull = {{(M_MAX-1){1'b0}}, poly} | ({{(2*M_MAX-2){1'b0}}, 1'b1} << m);
        for (int i = 2*M_MAX-2; i >= 1; i--) begin
            if ((i >= int'(m)) && prod[i]) prod = prod ^ (pfull << (i - int'(m)));
            else                           prod = prod;
        end
        return prod[M_MAX-1:0] & low_mask(m);
    endfunction

    state_t             state_q, state_d;
    logic [M_MAX-1:0]   sq_q, sq_d, res_q, res_d, poly_q, poly_d, inv_q, inv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]      m_q, m_d;
    logic               err_q, err_d, valid_q, valid_d, in_ready_q, in_ready_d;

    logic [M_MAX-1:0]   sq2_s, res_n_s, sel_poly_s, a_mask_s;
    logic [MW-1:0]      sel_m_s;
    logic               m_ok_s;

    // Next-state and datapath computation.
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        poly_d  = poly_q;
        inv_d   = inv_q;
        err_d   = err_q;
        valid_d = valid_q;

        sq2_s   = gf_mul(sq_q, sq_q, poly_q, m_q);
        res_n_s = gf_mul(res_q, sq2_s, poly_q, m_q);

        case (i_code)
            2'd0:    begin sel_m_s = MW'(6);  sel_poly_s = M_MAX'(8'h03);  end
            2'd1:    begin sel_m_s = MW'(8);  sel_poly_s = M_MAX'(8'h1D);  end
            2'd2:    begin sel_m_s = MW'(10); sel_poly_s = M_MAX'(10'h009); end
            default: begin sel_m_s = i_m;     sel_poly_s = i_poly & low_mask(i_m); end
        endcase
        m_ok_s   = (i_code != 2'd3) || ((i_m >= MW'(2)) && (int'(i_m) <= M_MAX));
        a_mask_s = i_a & low_mask(sel_m_s);

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    m_d    = sel_m_s;
                    poly_d = sel_poly_s;
                    if (!m_ok_s || (a_mask_s == '0)) begin
                        state_d = S_DONE;
                        inv_d   = '0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        sq_d    = a_mask_s;
                        res_d   = M_MAX'(1'b1);
                        cnt_d   = CNT_W'(sel_m_s) - CNT_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sq_d  = sq2_s;
                res_d = res_n_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    inv_d   = res_n_s;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            sq_q       <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            m_q        <= '0;
            poly_q     <= '0;
            inv_q      <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sq_q       <= sq_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            poly_q     <= poly_d;
            inv_q      <= inv_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_inv      = inv_q;
    assign o_err      = err_q;
    assign o_in_ready = in_ready_q;

endmodule

// File: tb/tb_gf_inv_seq.sv
// Directed bench for gf_inv_seq: known inverses, error paths, exhaustive
// round trip against an independent shift-and-reduce multiplier, backpressure, reset.
module tb_gf_inv_seq;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_in_ready;
    logic [9:0] i_a;
    logic [1:0] i_code;
    logic [3:0] i_m;
    logic [9:0] i_poly;
    logic       o_valid;
    logic       i_out_ready;
    logic [9:0] o_inv;
    logic       o_err;

    int n_cmp = 0;
    int n_bad = 0;

    gf_inv_seq #(.M_MAX(10), .CNT_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_a(i_a), .i_code(i_code), .i_m(i_m), .i_poly(i_poly),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_inv(o_inv), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift-and-add with reduction after every shift.
    function automatic int ref_mul(input int a, input int b, input int m, input int poly);
        int r = 0;
        int x = a;
        for (int i = 0; i < m; i++) begin
            if (((b >> i) & 1) == 1) r = r ^ x;
            x = x << 1;
            if (((x >> m) & 1) == 1) x = x ^ ((1 << m) | poly);
        end
        return r;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [1:0] code, input logic [3:0] m, input logic [9:0] poly,
                          input logic [9:0] a, output logic [9:0] inv, output logic err,
                          output int lat);
        i_code = code; i_m = m; i_poly = poly; i_a = a; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk); #1;
            lat++;
        end
        inv = o_inv;
        err = o_err;
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] inv;
        logic       err;
        int         lat;
        int         ref_m[3];
        int         ref_p[3];
        ref_m[0] = 6;  ref_p[0] = 'h03;
        ref_m[1] = 8;  ref_p[1] = 'h1D;
        ref_m[2] = 10; ref_p[2] = 'h009;

        i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b0;
        i_a = '0; i_code = '0; i_m = '0; i_poly = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_inv", o_inv, 0);
        check("rst_err", o_err, 0);
        check("rst_in_ready", o_in_ready, 1);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_op(2'd0, 4'd0, 10'h0, 10'h002, inv, err, lat);
        check("c0_inv", inv, 'h021); check("c0_err", err, 0); check("c0_lat", lat, 6);
        run_op(2'd1, 4'd0, 10'h0, 10'h002, inv, err, lat);
        check("c1_inv", inv, 'h08E); check("c1_err", err, 0); check("c1_lat", lat, 8);
        run_op(2'd2, 4'd0, 10'h0, 10'h002, inv, err, lat);
        check("c2_inv", inv, 'h204); check("c2_err", err, 0); check("c2_lat", lat, 10);

        run_op(2'd3, 4'd4, 10'h003, 10'h002, inv, err, lat);
        check("c3_inv2", inv, 'h009); check("c3_err", err, 0); check("c3_lat", lat, 4);
        run_op(2'd3, 4'd4, 10'h003, 10'h009, inv, err, lat);
        check("c3_inv9", inv, 'h002);

        run_op(2'd1, 4'd0, 10'h0, 10'h000, inv, err, lat);
        check("zero_err", err, 1); check("zero_inv", inv, 0); check("zero_lat", lat, 1);
        run_op(2'd3, 4'd1, 10'h003, 10'h001, inv, err, lat);
        check("m1_err", err, 1); check("m1_inv", inv, 0); check("m1_lat", lat, 1);
        run_op(2'd3, 4'd11, 10'h003, 10'h001, inv, err, lat);
        check("m11_err", err, 1);
        run_op(2'd0, 4'd0, 10'h0, 10'h3C0, inv, err, lat);
        check("mask_err", err, 1); check("mask_inv", inv, 0);

        for (int c = 0; c < 3; c++) begin
            for (int a = 1; a < (1 << ref_m[c]); a++) begin
                run_op(2'(c), 4'd0, 10'h0, 10'(a), inv, err, lat);
                check("rt_prod", ref_mul(a, int'(inv), ref_m[c], ref_p[c]), 1);
                check("rt_err", err, 0);
                check("rt_lat", lat, ref_m[c]);
                if (a == 1) check("rt_one", inv, 1);
            end
        end

        // Backpressure with a second operand already waiting on i_valid.
        i_code = 2'd0; i_a = 10'h002; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_code = 2'd1; i_a = 10'h002;
        lat = 1;
        while (!o_valid && lat < 64) begin
            check("run_in_ready", o_in_ready, 0);
            @(posedge i_clk); #1;
            lat++;
        end
        check("bp_lat", lat, 6);
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            check("bp_valid", o_valid, 1);
            check("bp_inv", o_inv, 'h021);
            check("bp_in_ready", o_in_ready, 0);
        end
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        check("hs_valid", o_valid, 0);
        check("hs_in_ready", o_in_ready, 1);
        check("hs_inv_kept", o_inv, 'h021);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("held_accept", o_in_ready, 0);
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check("held_lat", lat, 8);
        check("held_inv", o_inv, 'h08E);
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;

        // Reset in the third RUN cycle of a code-2 operation.
        i_code = 2'd2; i_a = 10'h002; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end
        i_rst = 1'b1;
        #1;
        check("mrst_valid", o_valid, 0);
        check("mrst_in_ready", o_in_ready, 1);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk); #1;
            check("mrst_no_pulse", o_valid, 0);
        end
        run_op(2'd2, 4'd0, 10'h0, 10'h002, inv, err, lat);
        check("post_rst_inv", inv, 'h204);
        check("post_rst_lat", lat, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gf_inv_seq.md
Name: gf_inv_seq

Overview:
Sequential GF(2^m) multiplicative inverter. It computes a^-1 = a^(2^m-2) by iterated square-and-multiply, using one squarer and one multiplier per cycle.
It is the parametrised successor to the combinational GF multiplier. It supports the three built-in field codes plus a fourth, programmable-polynomial mode, with widths up to M_MAX.
It sits in front of the Chien/Forney stage and supplies the error-evaluator denominator inverse. Valid/ready handshakes are used on both input and output.

Parameters:
M_MAX, 10, maximum field degree and data width; legal range 10..16.
CNT_W, 5, width of the iteration counter; must satisfy 2^CNT_W > M_MAX.

Ports:
i_clk  input  1  clock; all state updates on its rising edge.
i_rst  input  1  asynchronous active-high reset.
i_valid  input  1  operand request.
o_in_ready  output  1  block can accept an operand (high only in IDLE).
i_a  input  M_MAX  operand; bits at or above m are ignored (masked on load).
i_code  input  2  field select: 0 = m6, p=x^6+x+1; 1 = m8, p=x^8+x^4+x^3+x^2+1; 2 = m10, p=x^10+x^3+1; 3 = programmable.
i_m  input  4..5 (clog2(M_MAX+1))  field degree for code 3; ignored otherwise.
i_poly  input  M_MAX  low coefficients p[m-1:0] of p(x) for code 3; the x^m term is implicit.
o_valid  output  1  result available.
i_out_ready  input  1  consumer accepts the result.
o_inv  output  M_MAX  inverse, zero-extended above bit m-1.
o_err  output  1  qualifies o_valid: operand was zero, or the code-3 degree was illegal.

Behaviour:
Reset: asynchronous.
- State = IDLE; o_valid=0, o_inv=0, o_err=0, o_in_ready=1.
- All internal registers are cleared.
- Reset mid-RUN or mid-DONE aborts the operation; no result is produced.

FSM states: IDLE, RUN, DONE.

IDLE:
- o_in_ready=1.
- On i_valid=1, latch on that edge: code; m (6/8/10 from the built-in table, or i_m); poly; and a = i_a masked to m bits.
- Illegal m (code 3 with i_m < 2 or i_m > M_MAX), or masked a == 0 -> DONE with o_inv=0, o_err=1.
- Otherwise -> RUN with sq=a, res=1, cnt=m-1.

RUN (m-1 cycles):
- Each cycle computes sq2 = sq*sq mod p and res_n = res*sq2 mod p.
- Registers update: sq<=sq2, res<=res_n, cnt<=cnt-1.
- When cnt==1 on the edge, go to DONE and load o_inv<=res_n, o_err<=0.
- i_valid is ignored in RUN; o_in_ready=0.

DONE:
- o_valid=1; o_inv and o_err are held stable until i_out_ready=1.
- On the edge with o_valid & i_out_ready: go to IDLE, o_valid<=0.
- o_inv and o_err keep their last value after the handshake.
- There is no same-cycle new accept. o_in_ready rises the cycle after the handshake, so throughput is at most one operand per m+1 cycles.

Latency:
- Nonzero operand: o_valid rises m cycles after the accept edge (6, 8, 10 for codes 0/1/2).
- Zero or illegal operand: o_valid rises 1 cycle after the accept edge.

Arithmetic:
- Polynomial-basis product: 2M_MAX-1 bit carry-less product, reduced bit-by-bit from degree 2m-2 down to m using p.
- Reduction uses only the low m coefficients.
- Results are always < 2^m; upper bits are forced to 0.
- Built-in codes must give the same products as the existing gf_mult fields.

Boundaries:
- a=1 completes in m-1 RUN cycles and gives res=1.
- Code 3 does not check that p is irreducible. If p is reducible the result is undefined, but o_valid and the cycle timing are unchanged.
- An i_valid held high across DONE is accepted only after returning to IDLE.

Test Plan:
1. Built-in inverses: code 0, a=0x02 -> o_inv=0x021, o_err=0, o_valid 6 cycles after accept. Code 1, a=0x02 -> 0x08E after 8 cycles. Code 2, a=0x002 -> 0x204 after 10 cycles.
2. Programmable mode: code 3, i_m=4, i_poly=0x003 (x^4+x+1), a=0x2 -> o_inv=0x009 after 4 cycles. Then a=0x9 -> 0x002.
3. Errors and masking: code 1, a=0x000 -> o_valid one cycle after accept, o_err=1, o_inv=0. Code 3, i_m=1 -> o_err=1. Code 0, a=0x3C0 (masks to 0) -> o_err=1.
4. Exhaustive round trip: for every nonzero a in codes 0/1/2, check a * o_inv == 1 via a reference multiplier. a=1 -> 1.
5. Backpressure: i_out_ready low for 5 cycles in DONE -> o_valid and o_inv held stable. o_in_ready=0 throughout. o_in_ready returns to 1 the cycle after the handshake.
6. Reset mid-RUN: assert i_rst at cycle 3 of a code-2 operation -> o_valid=0 and o_in_ready=1 immediately. A new operand after release gives the correct inverse with no stale-result pulse.
